fp2_hadamard_sched: RTL and testbench
=====================================

# fp2_hadamard_sched

Round-robin scheduler that shares one fixed-latency Fp2 Hadamard unit (four Fp2 inputs x, y, z, t → x+y+z+t, x−y+z−t, x+y−z−t, x−y−z+t) among several requesters in the isogeny datapath. It accepts at most one operation per cycle and tags each operation with its requester ID in a valid/tag shift pipeline matched to the unit latency. Results are returned on a shared response bus. The Hadamard unit has no handshake and cannot stall, so this block is the only path to it.

## Interface
- NREQ, 4: number of requesters (2..8)
- W, 255: Fp element width
- LATENCY, 16: cycles from had_* operand registers changing to had_out_* holding the matching result
- IDW, clog2(NREQ): requester ID width
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  NREQ  per-requester request
- req_ready  out  NREQ  per-requester accept (at most one bit high)
- req_data  in  NREQ*8*W  per-requester operands; slice i packs {x_re,x_im,y_re,y_im,z_re,z_im,t_re,t_im}, x_re at MSB
- quiesce  in  1  when high, no new requests are granted
- had_in  out  8*W  registered operands to the Hadamard unit, same packing
- had_out  in  8*W  results from the Hadamard unit {X_re,X_im,Y_re,Y_im,Z_re,Z_im,T_re,T_im}
- rsp_valid  out  1  result valid, one-cycle pulse per operation
- rsp_id  out  IDW  requester ID of the result
- rsp_data  out  8*W  registered result
- idle  out  1  no operation in flight and no response pending

## Operation
- Per-requester busy bit: at most one outstanding operation per requester. Set on accept; cleared at the edge that registers that requester's response.
- Eligible i: req_valid[i] & ~busy[i] & ~quiesce.
- Arbitration: combinational round-robin over eligible requesters, starting at rr_ptr. req_ready[i] is high only for the winner. Accept = req_valid[i] & req_ready[i].
- On accept at edge E: had_in ← req_data slice i; tag pipe stage 0 ← {1, i}; rr_ptr ← (i+1) mod NREQ.
- No accept: had_in holds its value; stage 0 ← {0, x}; rr_ptr unchanged.
- Tag pipe: LATENCY stages shifting every cycle, no stall.
- When the last stage is valid, the next edge loads rsp_data ← had_out, rsp_id ← tag, rsp_valid ← 1, and clears busy[tag]. Otherwise rsp_valid ← 0 and rsp_data holds.
- There is no response backpressure. Consumers must sink rsp_valid every cycle.
- idle = ~|tag-pipe valid bits & ~rsp_valid.
- Optional free-running count of accepted operations is not part of the interface.

## Timing
- Reset (synchronous): req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, had_in=0, all tag valids=0, busy=0, rr_ptr=0, idle=1.
- Reset mid-operation discards in-flight operations. Stale had_out values are never reported.
- Accept at edge E → rsp_valid high in the cycle after edge E+LATENCY+1. With LATENCY=16 that is 17 cycles after accept.
- Throughput: one accept per cycle across requesters.
- Same requester: re-request is possible in the cycle after its rsp_valid, giving an issue interval of LATENCY+2 cycles.
- Accept for requester j on the same edge as the response for j: impossible, because busy[j] is still set.
- Accept for requester k on the same edge as the response for j≠k: both happen.
- quiesce rising: takes effect combinationally in the same cycle. In-flight operations complete normally, and idle rises after the last response.
- Deasserting req_valid while not granted is legal. req_data must be stable while req_valid is high and the request is not yet accepted.

## Test plan
- Reset: hold rst 3 cycles with all req_valid=1 → req_ready=0, rsp_valid=0, idle=1. First grant after release goes to requester 0.
- Single op: requester 2 sends x=1, y=2, z=3, t=4 (imag parts 0) at edge E → rsp_valid pulses one cycle after E+17 with rsp_id=2 and real parts 10, p−2, p−4, 0 (p = field prime).
- Fairness: all 4 requesters valid continuously → grants 0,1,2,3 on consecutive cycles, then no grants until each response. Responses arrive in the same order with IDs 0,1,2,3.
- Back-to-back same ID: requester 1 re-asserts immediately → second accept exactly one cycle after its first rsp_valid. No grant occurs while busy[1]=1.
- Quiesce: issue 3 ops, then raise quiesce with new requests pending → no further req_ready. All 3 responses arrive; idle=1 after the last one.
- Reset mid-flight: accept 2 ops, assert rst at cycle 5 → no rsp_valid ever appears for those ops. Busy bits are cleared and requests are re-accepted right after reset.

Source files
------------

// File: rtl/fp2_hadamard_sched_if.sv
// Request/response bus shared by the requesters, the scheduler and the Fp2 Hadamard unit.
interface fp2_hadamard_sched_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 255
);
    localparam int unsigned IDW = $clog2(NREQ);
    localparam int unsigned DW  = 8 * W;

    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*DW-1:0] req_data;
    logic               quiesce;
    logic [DW-1:0]      had_in;
    logic [DW-1:0]      had_out;
    logic               rsp_valid;
    logic [IDW-1:0]     rsp_id;
    logic [DW-1:0]      rsp_data;
    logic               idle;

    // master: requesters together with the Hadamard unit; slave: the scheduler
    modport master (
        output req_valid, req_data, quiesce, had_out,
        input  req_ready, had_in, rsp_valid, rsp_id, rsp_data, idle
    );
    modport slave (
        input  req_valid, req_data, quiesce, had_out,
        output req_ready, had_in, rsp_valid, rsp_id, rsp_data, idle
    );
endinterface

// File: rtl/fp2_hadamard_sched.sv
// Round-robin scheduler sharing one fixed-latency, non-stallable Fp2 Hadamard unit among NREQ requesters.
module fp2_hadamard_sched #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned W       = 255,
    parameter int unsigned LATENCY = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    fp2_hadamard_sched_if.slave  sched_if
);
    localparam int unsigned IDW   = $clog2(NREQ);
    localparam int unsigned DW    = 8 * W;
    // Stage 0 loads with had_in; the unit's LATENCY counts from that register, so one extra stage.
    localparam int unsigned DEPTH = LATENCY + 1;

    logic [NREQ-1:0]  busy_q, busy_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [IDW-1:0]   tag_q [DEPTH];
    logic [IDW-1:0]   tag_d [DEPTH];
    logic [DW-1:0]    had_in_q, had_in_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [DW-1:0]    rsp_data_q, rsp_data_d;
    logic             idle_q, idle_d;

    logic [NREQ-1:0]  elig_c;
    logic [NREQ-1:0]  grant_c;
    logic             grant_any_c;
    logic [IDW-1:0]   grant_id_c;
    logic [DW-1:0]    grant_data_c;
    int unsigned      idx_c;

    // First eligible requester at or after rr_ptr wins.
    always_comb begin
        elig_c      = sched_if.req_valid & ~busy_q & {NREQ{~sched_if.quiesce & ~rst}};
        grant_any_c = 1'b0;
        grant_id_c  = '0;
        idx_c       = '0;
        grant_c     = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx_c = (32'(rr_ptr_q) + k) % NREQ;
            if (!grant_any_c && elig_c[IDW'(idx_c)]) begin
                grant_any_c = 1'b1;
                grant_id_c  = IDW'(idx_c);
            end
        end
        if (grant_any_c) begin
            grant_c[grant_id_c] = 1'b1;
        end
    end

    always_comb begin
        grant_data_c = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant_c[i]) begin
                grant_data_c = sched_if.req_data[i*DW +: DW];
            end
        end
    end

    always_comb begin
        busy_d      = busy_q;
        rr_ptr_d    = rr_ptr_q;
        had_in_d    = had_in_q;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        vld_d       = {vld_q[DEPTH-2:0], grant_any_c};
        tag_d[0]    = grant_id_c;
        for (int unsigned s = 1; s < DEPTH; s++) begin
            tag_d[s] = tag_q[s-1];
        end
        // Oldest tag retires: its busy bit drops on the edge that registers the response.
        if (vld_q[DEPTH-1]) begin
            rsp_valid_d            = 1'b1;
            rsp_id_d               = tag_q[DEPTH-1];
            rsp_data_d             = sched_if.had_out;
            busy_d[tag_q[DEPTH-1]] = 1'b0;
        end
        if (grant_any_c) begin
            had_in_d = grant_data_c;
            busy_d   = busy_d | grant_c;
            rr_ptr_d = (grant_id_c == IDW'(NREQ - 1)) ? '0 : grant_id_c + IDW'(1);
        end
        idle_d = ~(|vld_d) & ~rsp_valid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q      <= '0;
            rr_ptr_q    <= '0;
            vld_q       <= '0;
            had_in_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            idle_q      <= 1'b1;
            for (int unsigned s = 0; s < DEPTH; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            busy_q      <= busy_d;
            rr_ptr_q    <= rr_ptr_d;
            vld_q       <= vld_d;
            tag_q       <= tag_d;
            had_in_q    <= had_in_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            idle_q      <= idle_d;
        end
    end

    assign sched_if.req_ready = grant_c;
    assign sched_if.had_in    = had_in_q;
    assign sched_if.rsp_valid = rsp_valid_q;
    assign sched_if.rsp_id    = rsp_id_q;
    assign sched_if.rsp_data  = rsp_data_q;
    assign sched_if.idle      = idle_q;
endmodule

// File: tb/tb_fp2_hadamard_sched.sv
// Bench for fp2_hadamard_sched: operation-level scoreboard plus a registered Hadamard unit model.
module tb_fp2_hadamard_sched;
    localparam int NREQ = 4;
    localparam int W    = 255;
    localparam int LAT  = 16;
    localparam int DW   = 8 * W;

    typedef logic [W:0] val_t;
    localparam val_t TWO_W = {1'b1, {W{1'b0}}};
    localparam val_t P     = TWO_W - val_t'(19);

    typedef struct {
        int            due;
        int            id;
        logic [DW-1:0] data;
    } op_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp2_hadamard_sched_if #(.NREQ(NREQ), .W(W)) bus ();
    fp2_hadamard_sched #(.NREQ(NREQ), .W(W), .LATENCY(LAT)) dut (
        .clk      (clk),
        .rst      (rst),
        .sched_if (bus)
    );

    // Field arithmetic mod p = 2^255 - 19
    function automatic logic [W-1:0] addm(input logic [W-1:0] a, input logic [W-1:0] b);
        val_t s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= P) s = s - P;
        return s[W-1:0];
    endfunction

    function automatic logic [W-1:0] subm(input logic [W-1:0] a, input logic [W-1:0] b);
        val_t s;
        if (a >= b) s = {1'b0, a} - {1'b0, b};
        else        s = {1'b0, a} + P - {1'b0, b};
        return s[W-1:0];
    endfunction

    function automatic logic [W-1:0] comp(input logic [DW-1:0] v, input int k);
        return v[DW-1-k*W -: W];
    endfunction

    function automatic logic [DW-1:0] hadamard(input logic [DW-1:0] v);
        logic [DW-1:0] r;
        logic [W-1:0]  x, y, z, t;
        r = '0;
        for (int c = 0; c < 2; c++) begin
            x = comp(v, c);
            y = comp(v, 2 + c);
            z = comp(v, 4 + c);
            t = comp(v, 6 + c);
            r[DW-1-c*W -: W]     = addm(addm(x, y), addm(z, t));
            r[DW-1-(2+c)*W -: W] = subm(addm(x, z), addm(y, t));
            r[DW-1-(4+c)*W -: W] = subm(addm(x, y), addm(z, t));
            r[DW-1-(6+c)*W -: W] = subm(addm(x, t), addm(y, z));
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] mk_op(
        input logic [W-1:0] xr, input logic [W-1:0] xi, input logic [W-1:0] yr, input logic [W-1:0] yi,
        input logic [W-1:0] zr, input logic [W-1:0] zi, input logic [W-1:0] tr, input logic [W-1:0] ti);
        return {xr, xi, yr, yi, zr, zi, tr, ti};
    endfunction

    // Hadamard unit: result for the operands present LAT edges earlier
    logic [DW-1:0] hpipe [LAT];
    always @(posedge clk) begin
        hpipe[0] <= bus.had_in;
        for (int s = 1; s < LAT; s++) hpipe[s] <= hpipe[s-1];
    end
    assign bus.had_out = hadamard(hpipe[LAT-1]);

    // Scoreboard state
    op_t           ops[$];
    bit            m_busy [NREQ];
    int            m_ptr;
    logic [DW-1:0] m_had;
    bit            m_rsp_valid;
    int            m_rsp_id;
    logic [DW-1:0] m_rsp_data;
    int            edge_n;
    bit            st_rst, st_acc;
    int            st_id;
    logic [DW-1:0] st_data;
    int            total;
    int            bad;

    // Observed DUT events
    int            grant_e[$];
    int            grant_i[$];
    int            rsp_e[$];
    int            rsp_i[$];
    logic [DW-1:0] rsp_d[$];

    task automatic chk(input string name, input val_t act, input val_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        chk(name, val_t'(act), val_t'(exp));
    endtask

    function automatic int winner();
        if (rst) return -1;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (m_ptr + k) % NREQ;
            if (bus.req_valid[idx] && !m_busy[idx] && !bus.quiesce) return idx;
        end
        return -1;
    endfunction

    task automatic apply_edge();
        int  hit;
        op_t o;
        if (st_rst) begin
            ops.delete();
            foreach (m_busy[i]) m_busy[i] = 1'b0;
            m_ptr       = 0;
            m_had       = '0;
            m_rsp_valid = 1'b0;
            m_rsp_id    = 0;
            m_rsp_data  = '0;
        end else begin
            m_rsp_valid = 1'b0;
            hit = -1;
            foreach (ops[i]) if (ops[i].due == edge_n) hit = i;
            if (hit >= 0) begin
                m_rsp_valid = 1'b1;
                m_rsp_id    = ops[hit].id;
                m_rsp_data  = ops[hit].data;
                m_busy[ops[hit].id] = 1'b0;
                ops.delete(hit);
            end
            if (st_acc) begin
                m_had         = st_data;
                m_busy[st_id] = 1'b1;
                m_ptr         = (st_id + 1) % NREQ;
                o.due  = edge_n + LAT + 1;
                o.id   = st_id;
                o.data = hadamard(st_data);
                ops.push_back(o);
            end
        end
    endtask

    task automatic compare();
        int              w;
        logic [NREQ-1:0] er;
        w  = winner();
        er = '0;
        if (w >= 0) er[w] = 1'b1;
        chk("req_ready", val_t'(bus.req_ready), val_t'(er));
        chk("rsp_valid", val_t'(bus.rsp_valid), val_t'(m_rsp_valid));
        chk("idle", val_t'(bus.idle), val_t'(ops.size() == 0 && !m_rsp_valid));
        if (m_rsp_valid) chk_int("rsp_id", int'(bus.rsp_id), m_rsp_id);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("rsp_data[%0d]", k), val_t'(comp(bus.rsp_data, k)), val_t'(comp(m_rsp_data, k)));
            chk($sformatf("had_in[%0d]", k), val_t'(comp(bus.had_in, k)), val_t'(comp(m_had, k)));
        end
    endtask

    // One cycle: account for the last edge, check at negedge, log, predict the next edge.
    task automatic tick();
        int w;
        @(negedge clk);
        edge_n++;
        apply_edge();
        compare();
        if (bus.rsp_valid) begin
            rsp_e.push_back(edge_n);
            rsp_i.push_back(int'(bus.rsp_id));
            rsp_d.push_back(bus.rsp_data);
        end
        for (int i = 0; i < NREQ; i++) begin
            if (bus.req_valid[i] && bus.req_ready[i]) begin
                grant_e.push_back(edge_n + 1);
                grant_i.push_back(i);
            end
        end
        w       = winner();
        st_rst  = rst;
        st_acc  = (w >= 0);
        st_id   = (w >= 0) ? w : 0;
        st_data = bus.req_data[st_id*DW +: DW];
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        grant_e.delete();
        grant_i.delete();
        rsp_e.delete();
        rsp_i.delete();
        rsp_d.delete();
    endtask

    task automatic wait_idle(input int max, input string name);
        int n;
        n = 0;
        while (!bus.idle && n < max) begin
            tick();
            n++;
        end
        chk(name, val_t'(bus.idle), val_t'(1));
    endtask

    task automatic wait_rsp(input int max, input string name);
        int n;
        n = 0;
        while (rsp_i.size() == 0 && n < max) begin
            tick();
            n++;
        end
        chk_int(name, rsp_i.size(), 1);
    endtask

    initial begin
        logic [W-1:0] pm1;
        total = 0;
        bad   = 0;
        edge_n = 0;
        st_rst = 1'b1;
        st_acc = 1'b0;
        st_id  = 0;
        st_data = '0;
        pm1 = P[W-1:0] - W'(1);
        rst = 1'b1;
        bus.quiesce   = 1'b0;
        bus.req_valid = '1;
        bus.req_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_data[i*DW +: DW] = mk_op(W'(i + 1), pm1, W'(5 * i), W'(7),
                                             pm1 - W'(i), W'(3), W'(2 * i), pm1);
        end

        // Reset held with every requester asking
        repeat (3) begin
            tick();
            chk("reset_req_ready", val_t'(bus.req_ready), '0);
            chk("reset_rsp_valid", val_t'(bus.rsp_valid), '0);
            chk("reset_idle", val_t'(bus.idle), val_t'(1));
        end

        // Fairness: four back-to-back grants 0..3, responses in the same order
        clear_logs();
        rst = 1'b0;
        repeat (4) tick();
        bus.req_valid = '0;
        wait_idle(40, "fair_drain");
        chk_int("fair_grant_count", grant_i.size(), 4);
        chk_int("fair_rsp_count", rsp_i.size(), 4);
        for (int i = 0; i < 4 && i < grant_i.size(); i++) begin
            chk_int($sformatf("fair_grant_id[%0d]", i), grant_i[i], i);
            chk_int($sformatf("fair_grant_gap[%0d]", i), grant_e[i] - grant_e[0], i);
        end
        for (int i = 0; i < 4 && i < rsp_i.size() && i < grant_e.size(); i++) begin
            chk_int($sformatf("fair_rsp_id[%0d]", i), rsp_i[i], i);
            chk_int($sformatf("fair_latency[%0d]", i), rsp_e[i] - grant_e[i], 17);
        end

        // Single op from requester 2: x=1, y=2, z=3, t=4
        clear_logs();
        bus.req_data[2*DW +: DW] = mk_op(W'(1), '0, W'(2), '0, W'(3), '0, W'(4), '0);
        bus.req_valid = 4'b0100;
        tick();
        bus.req_valid = '0;
        wait_rsp(30, "single_rsp_seen");
        if (rsp_i.size() > 0 && grant_e.size() > 0) begin
            chk_int("single_rsp_id", rsp_i[0], 2);
            chk_int("single_latency", rsp_e[0] - grant_e[0], 17);
            chk("single_X_re", val_t'(comp(rsp_d[0], 0)), val_t'(10));
            chk("single_Y_re", val_t'(comp(rsp_d[0], 2)), P - val_t'(2));
            chk("single_Z_re", val_t'(comp(rsp_d[0], 4)), P - val_t'(4));
            chk("single_T_re", val_t'(comp(rsp_d[0], 6)), '0);
            chk("single_X_im", val_t'(comp(rsp_d[0], 1)), '0);
        end
        wait_idle(10, "single_idle");

        // Same requester re-asserting: issue interval LATENCY+2
        clear_logs();
        bus.req_valid = 4'b0010;
        repeat (45) tick();
        bus.req_valid = '0;
        wait_idle(40, "b2b_drain");
        chk_int("b2b_grant_count", grant_e.size(), 3);
        if (grant_e.size() >= 2 && rsp_e.size() >= 1) begin
            chk_int("b2b_interval", grant_e[1] - grant_e[0], 18);
            chk_int("b2b_after_rsp", grant_e[1] - rsp_e[0], 1);
            chk_int("b2b_grant_id", grant_i[1], 1);
        end

        // Quiesce with new requests pending
        clear_logs();
        bus.req_valid = 4'b0111;
        repeat (3) tick();
        bus.req_valid = '1;
        bus.quiesce   = 1'b1;
        wait_idle(40, "quiesce_drain");
        repeat (3) tick();
        chk_int("quiesce_grant_count", grant_i.size(), 3);
        chk_int("quiesce_rsp_count", rsp_i.size(), 3);
        chk("quiesce_idle_after", val_t'(bus.idle), val_t'(1));
        for (int i = 0; i < 3 && i < rsp_i.size(); i++) begin
            chk_int($sformatf("quiesce_rsp_id[%0d]", i), rsp_i[i], (i == 0) ? 2 : i - 1);
        end
        bus.quiesce   = 1'b0;
        bus.req_valid = '0;

        // Reset mid-flight discards two operations
        clear_logs();
        bus.req_valid = 4'b0011;
        repeat (2) tick();
        bus.req_valid = '0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        chk("midreset_idle", val_t'(bus.idle), val_t'(1));
        chk("midreset_rsp_valid", val_t'(bus.rsp_valid), '0);
        clear_logs();
        rst = 1'b0;
        bus.req_valid = 4'b0110;
        tick();
        chk_int("postreset_first_grant_count", grant_i.size(), 1);
        if (grant_i.size() > 0) chk_int("postreset_first_grant_id", grant_i[0], 1);
        tick();
        bus.req_valid = '0;
        wait_idle(40, "postreset_drain");
        repeat (20) tick();
        chk_int("postreset_grant_count", grant_i.size(), 2);
        chk_int("postreset_rsp_count", rsp_i.size(), 2);
        for (int i = 0; i < 2 && i < rsp_i.size(); i++) begin
            chk_int($sformatf("postreset_rsp_id[%0d]", i), rsp_i[i], i + 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
